mem_stall_ctrl: RTL
===================

Name: mem_stall_ctrl

Overview:
- MEM-stage data-memory port controller.
- Converts single-cycle load/store requests from the pipeline into req/ack transactions on a multi-cycle data bus.
- Drives `stall_all` into the hazard unit, which freezes every pipeline stage until the access completes.
- Handles byte-lane steering, load sign/zero extension, misalignment detection and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles waiting for `bus_ack` before the access is aborted.
- ADDR_WIDTH, 32: width of `mem_addr` and `bus_addr`.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  MEM-stage instruction is a load
- mem_write  in  1  MEM-stage instruction is a store
- mem_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- mem_addr  in  ADDR_WIDTH  byte address
- mem_wdata  in  32  store data, right-aligned
- mem_rdata  out  32  extended load result; valid in DONE
- stall_all  out  1  freeze the whole pipeline
- misaligned  out  1  current access is misaligned and suppressed
- bus_err  out  1  one-cycle pulse in DONE when the access timed out
- bus_req  out  1  transaction request, registered
- bus_we  out  1  write enable
- bus_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-steered write data
- bus_ack  in  1  slave completion, single-cycle pulse
- bus_rdata  in  32  read word; valid when `bus_ack` = 1

Behaviour:
- Reset values:
  - state = IDLE
  - `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata` = 0
  - `mem_rdata` = 0, `bus_err` = 0
  - counter = 0
  - `stall_all` = 0, except that `stall_all` is combinational and may assert in IDLE when `access` is high.
- Access definition: `access` = (`mem_read` | `mem_write`) & !`misaligned`. If both read and write are high, the access is a write.
- Misaligned definition: h/hu with `addr[0]` = 1, or w with `addr[1:0]` != 0.
  - `misaligned` is combinational.
  - No bus transaction, no stall; `mem_rdata` = 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - `stall_all` = `access`.
  - If `access`, capture `bus_addr`/`bus_we`/`bus_be`/`bus_wdata`, set `bus_req` = 1, clear counter, go to REQ.
- REQ:
  - `stall_all` = 1.
  - `bus_req` and all bus outputs are held stable until ack.
  - Counter increments every cycle.
  - If `bus_ack`: latch `bus_rdata`, drop `bus_req`, go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: drop `bus_req`, latch rdata = 0, set error flag, go to DONE.
  - Ack has priority over timeout when both occur in the same cycle.
- DONE:
  - `stall_all` = 0, so the pipeline advances at the end of this cycle.
  - `mem_rdata` = extended latched word.
  - `bus_err` = error flag.
  - Always go to IDLE. No re-trigger on the still-present MEM instruction.
- Latency: ack in the first REQ cycle gives 2 stall cycles; an ack n cycles after entering REQ gives n+2 stall cycles. Timeout gives TIMEOUT_CYCLES+1 stall cycles.
- `bus_ack` outside REQ is ignored.
- Byte-lane steering:
  - sb: `be` = 1<<`addr[1:0]`, `wdata` = byte replicated ×4.
  - sh: `be` = 0011 or 1100 by `addr[1]`, `wdata` = half replicated ×2.
  - sw: `be` = 1111.
  - Loads: `be` = 1111.
- Load extension: select byte/half from the latched word by `addr[1:0]`; sign-extend for b/h, zero-extend for bu/hu.
- Reset mid-operation: returns to IDLE next edge, `bus_req` deasserts, and a late ack is ignored. The slave must tolerate a withdrawn request.
- Counter width: $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

Decomposition:
- Add to `core_pkg`:
  - funct3 load/store constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`)
  - `mem_state_t` enum {IDLE, REQ, DONE}
- Combinational sub-module `load_store_align`:
  - `be`/`wdata` steering
  - load extension
  - `misaligned` detection
- The FSM and counter stay in `mem_stall_ctrl`.

Test Plan:
- lw `addr` 0x100, ack 3 cycles after REQ entry with rdata 0xDEADBEEF -> `stall_all` high 5 cycles; `mem_rdata` = 0xDEADBEEF in DONE; `bus_addr` = 0x100, `be` = 1111 stable throughout REQ.
- sb `addr` 0x203, `wdata` 0x000000A5, immediate ack -> `bus_we` = 1, `be` = 1000, `bus_wdata` = 0xA5A5A5A5, `bus_addr` = 0x200, 2 stall cycles.
- lb `addr` 0x101 with rdata 0x0000_80_00 -> `mem_rdata` = 0xFFFFFF80; lbu same -> 0x00000080; lh `addr` 0x102 with rdata 0x8001_0000 -> 0xFFFF8001.
- lw `addr` 0x102 -> `misaligned` = 1, `bus_req` never asserts, `stall_all` = 0.
- Load with no ack, TIMEOUT_CYCLES = 16 -> `bus_req` drops after 16 REQ cycles; DONE shows `bus_err` = 1 and `mem_rdata` = 0; next access proceeds normally.
- Reset asserted in 2nd REQ cycle, then ack 1 cycle later -> state IDLE, `bus_req` = 0, `stall_all` = 0, late ack ignored, no DONE pulse.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the MEM-stage data-memory controller.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Multi-cycle data bus between the MEM-stage controller (master) and the data slave.
interface mem_stall_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [31:0]           bus_wdata;
    logic                  bus_ack;
    logic [31:0]           bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_stall_ctrl_align.sv
// Byte-lane steering for stores, misalignment detection, and load extension.
module load_store_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_write,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be         = 4'hF;
        wdata_lane = wdata;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                if (is_write) begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
            end
            F3_H, F3_HU: begin
                misaligned = addr_lo[0];
                if (is_write) begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
            end
            F3_W:    misaligned = (addr_lo != 2'b00);
            default: ;
        endcase
    end

    always_comb begin
        case (ld_addr_lo)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'b0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'b0, ld_half};
            default: ld_data = ld_word;
        endcase
    end
endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory port controller: turns single-cycle load/store requests
// into req/ack bus transactions and freezes the pipeline while one is in flight.
//
// state | meaning
// IDLE  | no transaction; stall follows a valid access request
// REQ   | bus_req held, waiting for ack or timeout
// DONE  | result/error presented for one cycle, pipeline advances
module mem_stall_ctrl
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            mem_funct3,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  stall_all,
    output logic                  misaligned,
    output logic                  bus_err,
    mem_stall_ctrl_if.master      bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

    mem_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [2:0]    f3_q;
    logic [1:0]    lo_q;

    logic          mis_raw, access, capture, ack_take, timeout;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata, ld_data;

    load_store_align u_align (
        .funct3     (mem_funct3),
        .addr_lo    (mem_addr[1:0]),
        .is_write   (mem_write),
        .wdata      (mem_wdata),
        .be         (lane_be),
        .wdata_lane (lane_wdata),
        .misaligned (mis_raw),
        .ld_funct3  (f3_q),
        .ld_addr_lo (lo_q),
        .ld_word    (rdata_q),
        .ld_data    (ld_data)
    );

    assign misaligned = mis_raw & (mem_read | mem_write);
    assign access     = (mem_read | mem_write) & ~mis_raw;
    assign mem_rdata  = (state == DONE) ? ld_data : 32'h0;
    assign bus_err    = (state == DONE) & err_q;

    always_comb begin
        state_nxt = state;
        stall_all = 1'b0;
        capture   = 1'b0;
        ack_take  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                stall_all = access;
                if (access) begin
                    capture   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                stall_all = 1'b1;
                // ack wins over a timeout landing in the same cycle
                if (bus.bus_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            f3_q          <= '0;
            lo_q          <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= mem_write;
                bus.bus_addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                bus.bus_be    <= lane_be;
                bus.bus_wdata <= mem_write ? lane_wdata : 32'h0;
                f3_q          <= mem_funct3;
                lo_q          <= mem_addr[1:0];
                cnt           <= '0;
                err_q         <= 1'b0;
            end else if (state == REQ) begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                if (ack_take) begin
                    bus.bus_req <= 1'b0;
                    rdata_q     <= bus.bus_rdata;
                    err_q       <= 1'b0;
                end else if (timeout) begin
                    bus.bus_req <= 1'b0;
                    rdata_q     <= '0;
                    err_q       <= 1'b1;
                end
            end
        end
    end
endmodule
